// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) arbiter onto one RAM port; D has priority, bounded by a streak limit.
// Latency: strobes 1 cycle after grant, hit is combinational with ram_ready; one IDLE bubble between accesses.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    output logic              ihit,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    input  logic [1:0]        dwidth,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [1:0]        ram_width,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        streak_q;
    logic [3:0]        streak_d;
    logic [7:0]        timer_q;
    logic [7:0]        timer_d;
    logic              err_d;
    logic              ren_d;
    logic              wen_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [1:0]        width_d;
    logic              d_req;
    logic              i_forced;

    assign d_req    = dren | dwen;
    assign i_forced = iren && (streak_q == STREAK_MAX);

    // Hits and read data are pass-through in the completing cycle; zero otherwise.
    assign ihit  = (state_q == IBUSY) && ram_ready;
    assign dhit  = (state_q == DBUSY) && ram_ready;
    assign idata = ihit ? ram_rdata : '0;
    assign dload = dhit ? ram_rdata : '0;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        err_d    = err;
        ren_d    = ram_ren;
        wen_d    = ram_wen;
        addr_d   = ram_addr;
        wdata_d  = ram_wdata;
        width_d  = ram_width;

        case (state_q)
            IDLE: begin
                if (d_req && !i_forced) begin
                    state_d = DBUSY;
                    timer_d = '0;
                    addr_d  = daddr;
                    wdata_d = dstore;
                    width_d = dwidth;
                    wen_d   = dwen;
                    ren_d   = !dwen;
                    if (!iren) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (iren) begin
                    state_d  = IBUSY;
                    timer_d  = '0;
                    streak_d = '0;
                    addr_d   = iaddr;
                    width_d  = 2'd2;
                    ren_d    = 1'b1;
                    wen_d    = 1'b0;
                end
            end
            IBUSY, DBUSY: begin
                if (ram_ready) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end else if (timer_q == TIMER_LAST) begin
                    // Abort: the requester retries simply by keeping its level asserted.
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            timer_q   <= '0;
            err       <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_width <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            timer_q   <= timer_d;
            err       <= err_d;
            ram_ren   <= ren_d;
            ram_wen   <= wen_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            ram_width <= width_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(ihit && dhit));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TOUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iren = 1'b0, dren = 1'b0, dwen = 1'b0, ram_ready = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [DW-1:0] dstore = '0, ram_rdata = '0;
    logic [1:0]    dwidth = '0;
    logic [DW-1:0] idata, dload, ram_wdata;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_width;
    logic          ihit, dhit, ram_ren, ram_wen, err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .iren(iren), .iaddr(iaddr), .idata(idata), .ihit(ihit),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dwidth(dwidth),
        .dload(dload), .dhit(dhit),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_width(ram_width), .ram_rdata(ram_rdata), .ram_ready(ram_ready), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the RAM port, what request it carries, how long it has waited.
    int            m_owner;  // 0 none, 1 fetch, 2 data
    int            m_age;
    int            m_streak;
    logic          m_err, m_ren, m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_width;
    logic          m_last_ihit, m_last_dhit;

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_streak = 0; m_err = 0; m_ren = 0; m_wen = 0;
        m_addr = '0; m_wdata = '0; m_width = '0; m_last_ihit = 0; m_last_dhit = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic e_ihit, e_dhit;
        if (rst) begin
            model_reset();
        end else begin
            e_ihit = (m_owner == 1) && ram_ready;
            e_dhit = (m_owner == 2) && ram_ready;
            chk("ihit", ihit, e_ihit);
            chk("dhit", dhit, e_dhit);
            chk("ram_ren", ram_ren, m_ren);
            chk("ram_wen", ram_wen, m_wen);
            chk("err", err, m_err);
            if (e_ihit) chk("idata", idata, ram_rdata);
            if (e_dhit && !m_wen) chk("dload", dload, ram_rdata);
            if (m_ren || m_wen) begin
                chk("ram_addr", ram_addr, m_addr);
                chk("ram_width", ram_width, m_width);
            end
            if (m_wen) chk("ram_wdata", ram_wdata, m_wdata);
            m_last_ihit = e_ihit;
            m_last_dhit = e_dhit;
            if (m_owner != 0) begin
                if (ram_ready) begin
                    m_owner = 0; m_ren = 0; m_wen = 0;
                end else begin
                    m_age++;
                    if (m_age >= TOUT) begin
                        m_owner = 0; m_ren = 0; m_wen = 0; m_err = 1;
                    end
                end
            end else if ((dren || dwen) && !(iren && m_streak == MAXS)) begin
                m_owner = 2; m_age = 0;
                m_addr = daddr; m_wdata = dstore; m_width = dwidth;
                m_wen = dwen; m_ren = !dwen;
                m_streak = iren ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            end else if (iren) begin
                m_owner = 1; m_age = 0; m_addr = iaddr; m_width = 2'd2;
                m_ren = 1; m_wen = 0; m_streak = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        string seq;
        #3;
        chk("rst_ram_ren", ram_ren, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_hits", {ihit, dhit}, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;

        // Single fetch, ready in second cycle after request.
        step(); iren = 1; iaddr = 32'h100;
        step(); #1;
        chk("fetch_ren", ram_ren, 1);
        chk("fetch_addr", ram_addr, 32'h100);
        chk("fetch_width", ram_width, 2);
        step(); ram_ready = 1; ram_rdata = 32'hDEADBEEF; #1;
        chk("fetch_ihit", ihit, 1);
        chk("fetch_idata", idata, 32'hDEADBEEF);
        step(); iren = 0; ram_ready = 0;

        // Simultaneous: D first, then I after one bubble.
        iren = 1; iaddr = 32'h100; dren = 1; daddr = 32'h2000;
        step(); ram_ready = 1; #1;
        chk("sim_dhit_c1", dhit, 1);
        chk("sim_daddr_c1", ram_addr, 32'h2000);
        chk("sim_ihit_c1", ihit, 0);
        step(); dren = 0; ram_ready = 0;
        step(); ram_ready = 1; #1;
        chk("sim_iren_c3", ram_ren, 1);
        chk("sim_iaddr_c3", ram_addr, 32'h100);
        chk("sim_ihit_c3", ihit, 1);
        step(); iren = 0; ram_ready = 0;

        // Starvation limit with both held and single-cycle RAM.
        iren = 1; dren = 1; ram_ready = 1;
        seq = "";
        for (int k = 1; k <= 22; k++) begin
            step(); #1;
            if (dhit) seq = {seq, "D"};
            if (ihit) seq = {seq, "I"};
        end
        chk("starve_seq", (seq == "DDDDIDDDDID"), 1);
        if (seq != "DDDDIDDDDID") $display("starvation hit order was %s", seq);
        iren = 0; dren = 0; ram_ready = 0;
        step();

        // Write wins over read.
        dren = 1; dwen = 1; daddr = 32'h40; dstore = 32'hA5; dwidth = 0;
        step(); #1;
        chk("wr_wen", ram_wen, 1);
        chk("wr_ren", ram_ren, 0);
        chk("wr_width", ram_width, 0);
        chk("wr_wdata", ram_wdata, 32'hA5);
        ram_ready = 1; #1;
        chk("wr_dhit", dhit, 1);
        step(); dren = 0; dwen = 0; ram_ready = 0;

        // Timeout: eight busy cycles without ready, then abort with sticky err.
        dren = 1; daddr = 32'h80;
        for (int k = 1; k <= TOUT; k++) begin
            step(); #1;
            chk("to_ren_held", ram_ren, 1);
            chk("to_no_dhit", dhit, 0);
            chk("to_err_low", err, 0);
        end
        step(); #1;
        chk("to_ren_drop", ram_ren, 0);
        chk("to_err_set", err, 1);
        dren = 0;
        step(); dren = 1; daddr = 32'h10;
        step(); ram_ready = 1; #1;
        chk("to_retry_dhit", dhit, 1);
        step(); dren = 0; ram_ready = 0; #1;
        chk("to_err_sticky", err, 1);

        // Asynchronous reset in the middle of a write.
        dwen = 1; daddr = 32'h44; dstore = 32'h1;
        step(); #1;
        chk("rstmid_wen_before", ram_wen, 1);
        ram_ready = 1; #1;
        chk("rstmid_dhit_before", dhit, 1);
        rst = 1; #1;
        chk("rstmid_wen", ram_wen, 0);
        chk("rstmid_dhit", dhit, 0);
        chk("rstmid_err", err, 0);
        @(negedge clk); #1 rst = 0; dwen = 0; ram_ready = 0;
        step(); ram_ready = 1; #1;
        chk("rstmid_idle", {ram_ren, ram_wen, dhit, ihit}, 0);
        ram_ready = 0;

        // Random traffic against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            if (iren && m_last_ihit) iren = $urandom_range(0, 1);
            else if (iren && $urandom_range(0, 63) == 0) iren = 0;
            else if (!iren && $urandom_range(0, 9) < 3) begin
                iren = 1; iaddr = $urandom;
            end
            if ((dren || dwen) && m_last_dhit) begin
                dren = 0; dwen = 0;
            end else if ((dren || dwen) && $urandom_range(0, 63) == 0) begin
                dren = 0; dwen = 0;
            end
            if (!dren && !dwen && $urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 2))
                    0: dren = 1;
                    1: dwen = 1;
                    default: begin dren = 1; dwen = 1; end
                endcase
                daddr = $urandom; dstore = $urandom; dwidth = 2'($urandom_range(0, 2));
            end
            ram_rdata = $urandom;
            ram_ready = ((cyc % 400) < 25) ? 1'b0 : ($urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
